// File: rtl/dsm_sigma_integrator.sv
// Sigma stage of a first-order delta-sigma modulator: saturating integrator plus
// a registered 1-bit quantizer, with a warm-up qualifier and a sticky saturation flag.
// The quantized bit feeds the upstream delta_feedback block, so the loop closes
// through exactly one register.
// Optional build macro: DSM_SIGMA_DITHER_EN adds LFSR dither to the quantizer decision only.
module dsm_sigma_integrator #(
  parameter int unsigned DELTA_WIDTH    = 5,
  parameter int unsigned ACC_WIDTH      = 8,
  parameter int unsigned WARMUP_SAMPLES = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic signed [DELTA_WIDTH-1:0] i_delta,
  input  logic                          i_sat_clr,
  output logic                          o_quantized_bit,
  output logic signed [ACC_WIDTH-1:0]   o_acc,
  output logic                          o_valid,
  output logic                          o_sat
);

  localparam int unsigned CntW = (WARMUP_SAMPLES < 1) ? 1 : $clog2(WARMUP_SAMPLES + 1);
  localparam logic [CntW-1:0] WarmLast = CntW'(WARMUP_SAMPLES);

  // Clamp limits expressed at the widened sum width.
  localparam logic signed [ACC_WIDTH:0] SumMax = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SumMin = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

  state_e                      state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_next;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        q_q, q_next;
  logic                        valid_q, valid_d;
  logic                        sat_q, sat_d;
  logic                        clamp_evt;

  // Widened add and clamp; an exact extreme value is representable and is not a clamp.
  always_comb begin
    sum       = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(i_delta);
    acc_next  = sum[ACC_WIDTH-1:0];
    clamp_evt = 1'b0;
    if (sum > SumMax) begin
      acc_next  = AccMax;
      clamp_evt = i_en;
    end else if (sum < SumMin) begin
      acc_next  = AccMin;
      clamp_evt = i_en;
    end
  end

`ifdef DSM_SIGMA_DITHER_EN
  logic [15:0]               lfsr_q;
  logic                      lfsr_fb;
  logic signed [ACC_WIDTH:0] dith_sum;

  // Dither only moves the decision threshold; the stored accumulator stays exact.
  always_comb begin
    lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    dith_sum = (ACC_WIDTH+1)'(acc_next) + (ACC_WIDTH+1)'($signed(lfsr_q[1:0]));
    q_next   = ~dith_sum[ACC_WIDTH];
  end

  // LFSR advances once per enabled sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q <= 16'hACE1;
    end else if (i_en) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  // Plain sign quantizer: 1 when the new accumulator is non-negative.
  always_comb begin
    q_next = ~acc_next[ACC_WIDTH-1];
  end
`endif

  // Warm-up FSM: discards the first WARMUP_SAMPLES enabled samples after reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (i_en) begin
      unique case (state_q)
        StIdle: begin
          if (WARMUP_SAMPLES == 0) begin
            state_d = StRun;
            valid_d = 1'b1;
          end else begin
            cnt_d   = CntW'(1);
            state_d = (cnt_d == WarmLast) ? StRun : StWarmup;
          end
        end
        StWarmup: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == WarmLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          valid_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Sticky saturation: a new clamp wins over a simultaneous clear.
  always_comb begin
    sat_d = clamp_evt | (sat_q & ~i_sat_clr);
  end

  // State registers; o_valid is registered alongside the sample it qualifies.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      if (i_en) begin
        acc_q <= acc_next;
        q_q   <= q_next;
      end
    end
  end

  assign o_acc           = acc_q;
  assign o_quantized_bit = q_q;
  assign o_valid         = valid_q;
  assign o_sat           = sat_q;

endmodule

// File: tb/tb_dsm_sigma_integrator.sv
// Bench for dsm_sigma_integrator: one instance with a 4-sample warm-up for the
// arithmetic/warm-up/saturation cases, one with no warm-up closed around a
// behavioural delta_feedback (DATA_WIDTH=4, FEEDBACK_MAG=8).
module tb_dsm_sigma_integrator;

  typedef struct {
    int acc;
    bit q;
    bit sat;
  } exp_t;

  logic clk;
  int   checks;
  int   failures;

  // Instance A: warm-up of 4 samples.
  logic              a_rst, a_en, a_clr;
  logic signed [4:0] a_delta;
  logic              a_q, a_valid, a_sat;
  logic signed [7:0] a_acc;

  // Instance B: no warm-up, closed-loop test.
  logic              b_rst, b_en, b_clr;
  logic signed [4:0] b_delta;
  logic              b_q, b_valid, b_sat;
  logic signed [7:0] b_acc;

  exp_t qa[$];
  exp_t qb[$];

  // Reference state for A.
  int m_acc;
  bit m_sat;
  int m_n;
  // Reference state for B.
  int mb_acc;
  bit mb_q;

  dsm_sigma_integrator #(
    .DELTA_WIDTH(5), .ACC_WIDTH(8), .WARMUP_SAMPLES(4)
  ) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_delta(a_delta), .i_sat_clr(a_clr),
    .o_quantized_bit(a_q), .o_acc(a_acc), .o_valid(a_valid), .o_sat(a_sat)
  );

  dsm_sigma_integrator #(
    .DELTA_WIDTH(5), .ACC_WIDTH(8), .WARMUP_SAMPLES(0)
  ) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_delta(b_delta), .i_sat_clr(b_clr),
    .o_quantized_bit(b_q), .o_acc(b_acc), .o_valid(b_valid), .o_sat(b_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Saturating add at ACC_WIDTH=8.
  function automatic void sat_add(input int acc, input int d, output int nacc, output bit evt);
    int s;
    s = acc + d;
    evt = 1'b0;
    nacc = s;
    if (s > 127) begin
      nacc = 127;
      evt  = 1'b1;
    end else if (s < -128) begin
      nacc = -128;
      evt  = 1'b1;
    end
  endfunction

  // Monitor A: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_sb_acc", int'(a_acc), e.acc);
        check("a_sb_bit", int'(a_q), int'(e.q));
        check("a_sb_sat", int'(a_sat), int'(e.sat));
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (b_valid) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_sb_acc", int'(b_acc), e.acc);
        check("b_sb_bit", int'(b_q), int'(e.q));
        check("b_sb_sat", int'(b_sat), int'(e.sat));
      end
    end
  end

  // One clock of stimulus on A; pushes the expectation for valid samples.
  task automatic step_a(input bit en, input int d, input bit clr);
    int  nacc;
    bit  evt;
    bit  exp_valid;
    exp_t e;
    a_en    = en;
    a_delta = 5'(d);
    a_clr   = clr;
    exp_valid = 1'b0;
    if (en) begin
      sat_add(m_acc, d, nacc, evt);
      m_acc = nacc;
      m_n++;
      exp_valid = (m_n > 4);
    end else begin
      evt = 1'b0;
    end
    m_sat = evt ? 1'b1 : (clr ? 1'b0 : m_sat);
    if (exp_valid) begin
      e.acc = m_acc;
      e.q   = (m_acc >= 0);
      e.sat = m_sat;
      qa.push_back(e);
    end
    @(posedge clk);
    #1;
    check("a_valid", int'(a_valid), int'(exp_valid));
  endtask

  task automatic reset_a();
    a_rst   = 1'b1;
    a_en    = 1'b1;
    a_delta = 5'sd7;
    a_clr   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_acc", int'(a_acc), 0);
      check("rst_bit", int'(a_q), 0);
      check("rst_valid", int'(a_valid), 0);
      check("rst_sat", int'(a_sat), 0);
    end
    a_rst = 1'b0;
    a_en  = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_acc", int'(a_acc), 0);
    check("post_rst_valid", int'(a_valid), 0);
    check("post_rst_sat", int'(a_sat), 0);
    m_acc = 0;
    m_sat = 1'b0;
    m_n   = 0;
  endtask

  // One closed-loop sample on B: delta = x - (+8 if last bit else -8).
  task automatic step_b(input int x);
    int  d;
    int  nacc;
    bit  evt;
    exp_t e;
    d = x - (mb_q ? 8 : -8);
    sat_add(mb_acc, d, nacc, evt);
    mb_acc = nacc;
    mb_q   = (nacc >= 0);
    e.acc  = mb_acc;
    e.q    = mb_q;
    e.sat  = 1'b0;
    qb.push_back(e);
    b_en    = 1'b1;
    b_delta = 5'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ones;
    checks   = 0;
    failures = 0;
    m_acc = 0; m_sat = 1'b0; m_n = 0;
    mb_acc = 0; mb_q = 1'b0;
    a_rst = 1'b1; a_en = 1'b0; a_delta = '0; a_clr = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_delta = '0; b_clr = 1'b0;
    @(posedge clk);
    #1;

    // Reset behaviour with enable active and a non-zero delta.
    reset_a();
    b_rst = 1'b0;

    // Warm-up: 4 discarded, 5th valid with 15.
    for (int i = 0; i < 5; i++) step_a(1'b1, 3, 1'b0);
    check("warm_valid", int'(a_valid), 1);
    check("warm_acc", int'(a_acc), 15);
    check("warm_bit", int'(a_q), 1);
    step_a(1'b1, 3, 1'b0);
    step_a(1'b0, 3, 1'b0);
    check("gap_hold_acc", int'(a_acc), 18);
    check("gap_valid", int'(a_valid), 0);
    step_a(1'b0, 9, 1'b0);
    check("gap_hold_acc2", int'(a_acc), 18);
    step_a(1'b1, 3, 1'b0);
    check("gap_resume_acc", int'(a_acc), 21);

    // Positive clamp.
    reset_a();
    for (int i = 0; i < 4; i++) step_a(1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) step_a(1'b1, 15, 1'b0);
    check("pos_acc8", int'(a_acc), 120);
    check("pos_sat8", int'(a_sat), 0);
    step_a(1'b1, 15, 1'b0);
    check("pos_acc9", int'(a_acc), 127);
    check("pos_sat9", int'(a_sat), 1);
    step_a(1'b1, 0, 1'b0);
    check("pos_sat_sticky", int'(a_sat), 1);
    check("pos_acc_hold", int'(a_acc), 127);

    // Clear alone, then clear colliding with a fresh clamp.
    step_a(1'b0, 0, 1'b1);
    check("clr_alone", int'(a_sat), 0);
    step_a(1'b1, 15, 1'b1);
    check("clr_vs_clamp", int'(a_sat), 1);
    check("clr_vs_clamp_acc", int'(a_acc), 127);

    // Negative boundary: exactly -128 is not a clamp.
    reset_a();
    for (int i = 0; i < 4; i++) step_a(1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) step_a(1'b1, -16, 1'b0);
    check("neg_acc8", int'(a_acc), -128);
    check("neg_sat8", int'(a_sat), 0);
    check("neg_bit8", int'(a_q), 0);
    step_a(1'b1, -16, 1'b0);
    check("neg_acc9", int'(a_acc), -128);
    check("neg_sat9", int'(a_sat), 1);
    step_a(1'b0, 0, 1'b0);

    // Closed loop, zero input: 1,1 then alternating 0,1.
    for (int k = 0; k < 16; k++) begin
      step_b(0);
      check("loop0_bit", int'(b_q), (k < 2) ? 1 : (k % 2));
    end
    // Closed loop, +4 input: about 3/4 ones.
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      step_b(4);
      if (b_q) ones++;
    end
    check("loop4_ones_in_range", int'(ones >= 47 && ones <= 49), 1);
    check("loop_sat", int'(b_sat), 0);
    b_en = 1'b0;

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    check("a_sb_drained", qa.size(), 0);
    check("b_sb_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
